// File: rtl/rv_fetch_pkg.sv
// ============================================================================
// Module   : rv_fetch_pkg
// Brief    : Shared types and constants for the RV32I fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_fetch_pkg;

  // Datapath width the prefetch entry is built around
  localparam int RV_XLEN = 32;

  // Canonical RV32I NOP (addi x0, x0, 0), shown to decode when nothing is buffered
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // One prefetched instruction together with the address it was fetched from
  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock show-ahead FIFO with synchronous flush.
//            DEPTH must be a power of two and at least 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // Pop only real data; a push into a full FIFO is accepted only when the head leaves the same cycle.
  // A flush discards whatever would have been written this cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && !i_flush && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/rv_fetch_unit.sv
// ============================================================================
// Module   : rv_fetch_unit
// Brief    : Decoupled RV32I instruction fetch. Holds the fetch PC, issues
//            reads to a 1-cycle synchronous instruction memory, buffers
//            {pc,instr} in a prefetch FIFO and hands them to decode over a
//            valid/ready handshake. Redirects flush everything in flight.
//            Build option: define FETCH_PERF_EN to build the delivered /
//            discarded performance counters (otherwise they read 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN       = RV_XLEN,
  parameter int              IMEM_AW    = 11,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_imem_req,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [31:0]        i_imem_rdata,
  input  logic               i_redirect,
  input  logic [XLEN-1:0]    i_redirect_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [31:0]        o_instr,
  output logic [XLEN-1:0]    o_pc,
  output logic [XLEN-1:0]    o_pc_plus4,
  output logic               o_misaligned,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_flush_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_misaligned;

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_used;
  logic            w_empty;
  logic            w_pop;
  logic            w_issue;

  // Credits include the outstanding read so a full FIFO can never be overrun by its response
  assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue = !i_reset && !i_redirect && (w_used < (CW+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && i_instr_ready;

  assign w_push_entry = {r_inflight_pc, i_imem_rdata};

  // The response is pushed the cycle after issue; a redirect flush suppresses it inside the FIFO
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Fetch PC, outstanding-read tracking and misalignment flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_misaligned  <= 1'b0;
    end else if (i_redirect) begin
      r_pc         <= {i_redirect_pc[XLEN-1:2], 2'b00};
      r_inflight   <= 1'b0;
      r_misaligned <= |i_redirect_pc[1:0];
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + XLEN'(4);
      end
    end
  end

  assign o_imem_req    = w_issue;
  assign o_imem_addr   = r_pc[IMEM_AW-1:0];
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_empty ? RV_NOP : w_head.instr;
  assign o_pc          = w_empty ? '0 : w_head.pc;
  assign o_pc_plus4    = o_pc + XLEN'(4);
  assign o_misaligned  = r_misaligned;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] w_flush_add;

  // Entries left after this cycle's pop plus any outstanding read are what a redirect throws away
  assign w_flush_add = 32'(w_count) - 32'(w_pop) + 32'(r_inflight);

  // Delivered / discarded counters, free-running with natural wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop)      r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_redirect) r_flush_cnt <= r_flush_cnt + w_flush_add;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_fetch_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_fetch_unit.sv
// ============================================================================
// Module   : tb_rv_fetch_unit
// Brief    : Self-checking bench for rv_fetch_unit against a queue-based
//            reference model; a second instance checks a wrapping RESET_PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: default RESET_PC, driven by the bench
  logic        req0, valid0, mis0;
  logic [10:0] addr0;
  logic [31:0] rdata0, instr0, pc0, pcp40, fcnt0, flcnt0;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;

  // Instance 1: RESET_PC near the top of the address space, always ready
  logic        req1, valid1, mis1;
  logic [10:0] addr1;
  logic [31:0] rdata1, instr1, pc1, pcp41, fcnt1, flcnt1;

  rv_fetch_unit dut0 (
    .i_clk(clk), .i_reset(rst),
    .o_imem_req(req0), .o_imem_addr(addr0), .i_imem_rdata(rdata0),
    .i_redirect(redir), .i_redirect_pc(redir_pc),
    .o_instr_valid(valid0), .i_instr_ready(ready),
    .o_instr(instr0), .o_pc(pc0), .o_pc_plus4(pcp40),
    .o_misaligned(mis0), .o_fetch_cnt(fcnt0), .o_flush_cnt(flcnt0)
  );

  rv_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .o_imem_req(req1), .o_imem_addr(addr1), .i_imem_rdata(rdata1),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_instr_valid(valid1), .i_instr_ready(1'b1),
    .o_instr(instr1), .o_pc(pc1), .o_pc_plus4(pcp41),
    .o_misaligned(mis1), .o_fetch_cnt(fcnt1), .o_flush_cnt(flcnt1)
  );

  // Address-tagged memory contents
  function automatic logic [31:0] memf(input logic [10:0] a);
    return 32'h5A00_003C ^ ({21'h0, a} << 8);
  endfunction

  // 1-cycle synchronous memories; garbage when not read so stray pushes are visible
  always @(posedge clk) rdata0 <= req0 ? memf(addr0) : $urandom();
  always @(posedge clk) rdata1 <= req1 ? memf(addr1) : $urandom();

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: fetch PC, one outstanding read, buffered PCs
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_q[$];
  bit          m_mis;
  logic [31:0] m_fcnt, m_flcnt;

  // Instance-1 observations
  logic [31:0] d1_pcs[$];
  logic [31:0] d1_plus4_at_top;

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_infl = 0; m_infl_pc = '0; m_q.delete();
    m_mis = 0; m_fcnt = '0; m_flcnt = '0;
  endtask

  // One clock cycle: drive inputs at negedge, compare, then advance the model
  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit          exp_valid, exp_req, pop;
    logic [31:0] e_f, e_fl;
    @(negedge clk);
    ready = rdy; redir = rd; redir_pc = rpc;
    #1;
    exp_valid = (m_q.size() != 0);
    exp_req   = !rd && ((m_q.size() + int'(m_infl)) < 4);
    chk("valid", valid0, exp_valid);
    chk("req", req0, exp_req);
    chk("addr", addr0, m_pc[10:0]);
    if (exp_valid) begin
      chk("pc", pc0, m_q[0]);
      chk("instr", instr0, memf(m_q[0][10:0]));
      chk("pc_plus4", pcp40, m_q[0] + 32'd4);
    end else begin
      chk("empty_instr", instr0, 32'h0000_0013);
      chk("empty_pc", pc0, 32'h0);
      chk("empty_pc_plus4", pcp40, 32'h4);
    end
    chk("misaligned", mis0, m_mis);
`ifdef FETCH_PERF_EN
    e_f = m_fcnt; e_fl = m_flcnt;
`else
    e_f = '0; e_fl = '0;
`endif
    chk("fetch_cnt", fcnt0, e_f);
    chk("flush_cnt", flcnt0, e_fl);

    if (valid1 && d1_pcs.size() < 4) begin
      d1_pcs.push_back(pc1);
      chk("d1_instr", instr1, memf(pc1[10:0]));
      if (pc1 == 32'hFFFF_FFFC) d1_plus4_at_top = pcp41;
    end

    pop = exp_valid && rdy;
    if (pop) begin
      void'(m_q.pop_front());
      m_fcnt++;
    end
    if (rd) begin
      m_flcnt += 32'(m_q.size()) + 32'(m_infl);
      m_q.delete();
      m_infl = 0;
      m_pc   = {rpc[31:2], 2'b00};
      m_mis  = |rpc[1:0];
    end else begin
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl = exp_req;
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    d1_plus4_at_top = 32'hDEAD_BEEF;
    model_reset(32'h0);
    #2;
    chk("rst_valid", valid0, 1'b0);
    chk("rst_req", req0, 1'b0);
    chk("rst_instr", instr0, 32'h0000_0013);
    chk("rst_pc_plus4", pcp40, 32'h4);
    chk("rst_misaligned", mis0, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;

    // Stall decode: FIFO fills to depth, head holds pc 0
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    // Redirect while decode takes the head in the same cycle
    step(1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    // Stall then drain: refill keeps up with ready held high
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

    // Wrapping reset PC on the second instance
    chk("d1_count", d1_pcs.size(), 4);
    if (d1_pcs.size() == 4) begin
      chk("d1_pc0", d1_pcs[0], 32'hFFFF_FFF8);
      chk("d1_pc1", d1_pcs[1], 32'hFFFF_FFFC);
      chk("d1_pc2", d1_pcs[2], 32'h0000_0000);
      chk("d1_pc3", d1_pcs[3], 32'h0000_0004);
    end
    chk("d1_plus4_wrap", d1_plus4_at_top, 32'h0);

    // Misaligned target, then aligned, then back-to-back redirects
    step(1'b1, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 32'h0000_0301);
    step(1'b0, 1'b1, 32'h0000_0400);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit          r_rdy, r_rd;
      logic [31:0] r_tgt;
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rd  = ($urandom_range(0, 15) == 0);
      r_tgt = $urandom();
      step(r_rdy, r_rd, r_tgt);
    end

    // Asynchronous reset mid-cycle while traffic is flowing
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    @(negedge clk);
    ready = 1'b1; redir = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_valid", valid0, 1'b0);
    chk("async_req", req0, 1'b0);
    chk("async_fetch_cnt", fcnt0, 32'h0);
    chk("async_flush_cnt", flcnt0, 32'h0);
    chk("async_misaligned", mis0, 1'b0);
    chk("async_d1_valid", valid1, 1'b0);
    chk("async_d1_cnt", fcnt1 | flcnt1 | 32'(mis1), 32'h0);
    model_reset(32'h0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
